// File: rtl/acc_pkg.sv
// Shared constants and FSM state encoding for the accelerator host.
// Latency: none (declarations only).
// Backpressure: n/a.
package acc_pkg;

  localparam logic [4:0]  ADDR_CTRL = 5'd16;
  localparam logic [4:0]  ADDR_ID   = 5'd17;
  localparam logic [31:0] CMD_START = 32'hFFFFFFFF;
  localparam logic [31:0] CMD_ACK   = 32'h0F0F0F0F;
  localparam logic [31:0] CMD_RST   = 32'hFF0000FF;
  localparam logic [31:0] ID_VALUE  = 32'h11111111;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    READ,
    ACK,
    OUT
`ifdef ACC_HOST_PROBE_EN
    , PROBE
`endif
  } state_t;

endpackage

// File: rtl/acc_host_timer.sv
// Loadable down-counter; done pulses for one cycle when the loaded count expires.
// Latency: done asserts load_val cycles after the cycle in which load is high.
// Backpressure: none; a new load restarts the count.
module acc_host_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] cnt_q;

  // Count down from the loaded value and park at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  // The last counted cycle is the one holding a count of one.
  assign done = (cnt_q == 8'd1);

endmodule

// File: rtl/acc_host.sv
// Streams a 512-bit block into an Avalon-MM hash accelerator and returns the 256-bit hash (optional ID probe: ACC_HOST_PROBE_EN).
// Latency: hash_valid rises 27+EXE_WAIT cycles after block accept.
// Backpressure: blk_ready only in IDLE; hash held stable until hash_ready.
module acc_host
  import acc_pkg::*;
#(
  parameter int EXE_WAIT = 80
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         hash_valid,
  input  logic         hash_ready,
  output logic [255:0] hash_data,
  output logic         m_chipselect,
  output logic         m_write,
  output logic         m_read,
  output logic [4:0]   m_address,
  output logic [31:0]  m_writedata,
  input  logic [31:0]  m_readdata
`ifdef ACC_HOST_PROBE_EN
  , output logic       probe_err
`endif
);

  state_t            state;
  logic [15:0][31:0] blk_q;
  logic [7:0][31:0]  hash_q;
  logic [4:0]        cnt;
  logic              rd_pend;
  logic [2:0]        rd_idx;
  logic              tmr_load;
  logic              tmr_done;
`ifdef ACC_HOST_PROBE_EN
  logic              probed;
`endif

  assign tmr_load     = (state == START);
  assign hash_data    = hash_q;
  assign m_chipselect = m_write | m_read;

  acc_host_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (8'(EXE_WAIT)),
    .done     (tmr_done)
  );

  // Main sequencer: registered bus outputs, one transaction per cycle at most.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      blk_ready   <= 1'b0;
      hash_valid  <= 1'b0;
      hash_q      <= '0;
      blk_q       <= '0;
      cnt         <= 5'd0;
      rd_pend     <= 1'b0;
      rd_idx      <= 3'd0;
      m_write     <= 1'b0;
      m_read      <= 1'b0;
      m_address   <= 5'd0;
      m_writedata <= 32'd0;
`ifdef ACC_HOST_PROBE_EN
      probe_err   <= 1'b0;
      probed      <= 1'b0;
`endif
    end else begin
      m_write     <= 1'b0;
      m_read      <= 1'b0;
      m_address   <= 5'd0;
      m_writedata <= 32'd0;
      // Hash reads return one cycle later; the ID read (address bit 4 set) is handled in PROBE.
      rd_pend     <= m_read && !m_address[4];
      rd_idx      <= m_address[2:0];
      if (rd_pend) begin
        hash_q[rd_idx] <= m_readdata;
      end
      case (state)
        IDLE: begin
`ifdef ACC_HOST_PROBE_EN
          if (!probed) begin
            state     <= PROBE;
            m_read    <= 1'b1;
            m_address <= ADDR_ID;
            cnt       <= 5'd0;
          end else
`endif
          if (blk_ready && blk_valid) begin
            blk_q       <= blk_data;
            blk_ready   <= 1'b0;
            state       <= LOAD;
            m_write     <= 1'b1;
            m_address   <= 5'd0;
            m_writedata <= blk_data[31:0];
            cnt         <= 5'd1;
          end else begin
            blk_ready <= 1'b1;
          end
        end
        LOAD: begin
          m_write <= 1'b1;
          if (cnt == 5'd16) begin
            state       <= START;
            m_address   <= ADDR_CTRL;
            m_writedata <= CMD_START;
          end else begin
            m_address   <= cnt;
            m_writedata <= blk_q[cnt[3:0]];
            cnt         <= cnt + 5'd1;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (tmr_done) begin
            state     <= READ;
            m_read    <= 1'b1;
            m_address <= 5'd0;
            cnt       <= 5'd1;
          end
        end
        READ: begin
          if (cnt == 5'd8) begin
            state       <= ACK;
            m_write     <= 1'b1;
            m_address   <= ADDR_CTRL;
            m_writedata <= CMD_ACK;
          end else begin
            m_read    <= 1'b1;
            m_address <= cnt;
            cnt       <= cnt + 5'd1;
          end
        end
        ACK: begin
          state      <= OUT;
          hash_valid <= 1'b1;
        end
        OUT: begin
          if (hash_ready) begin
            state      <= IDLE;
            hash_valid <= 1'b0;
            blk_ready  <= 1'b1;
          end
        end
`ifdef ACC_HOST_PROBE_EN
        PROBE: begin
          if (cnt == 5'd0) begin
            cnt <= 5'd1;
          end else begin
            probe_err <= probe_err | (m_readdata != ID_VALUE);
            probed    <= 1'b1;
            state     <= IDLE;
            blk_ready <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_host.sv
// Directed bench for acc_host with a latency-1 Avalon responder model.
// Latency: checks the full per-cycle bus sequence of every transaction.
// Backpressure: exercises held hash_ready and back-to-back blk_valid.
module tb_acc_host;

  localparam int W = 80;
  localparam int LAST = 27 + W;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         hash_valid;
  logic         hash_ready = 1'b0;
  logic [255:0] hash_data;
  logic         m_chipselect, m_write, m_read;
  logic [4:0]   m_address;
  logic [31:0]  m_writedata;
  logic [31:0]  m_readdata = 32'd0;
`ifdef ACC_HOST_PROBE_EN
  logic         probe_err;
`endif

  logic [255:0] rsp_hash = '0;
  logic [31:0]  id_val = 32'h22222222;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acc_host #(.EXE_WAIT(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .hash_valid   (hash_valid),
    .hash_ready   (hash_ready),
    .hash_data    (hash_data),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_read       (m_read),
    .m_address    (m_address),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata)
`ifdef ACC_HOST_PROBE_EN
    , .probe_err  (probe_err)
`endif
  );

  // Accelerator responder: read data valid the cycle after the read.
  always @(posedge clk) begin
    if (m_read) begin
      if (m_address == 5'd17)     m_readdata <= id_val;
      else if (m_address < 5'd8)  m_readdata <= rsp_hash[32*m_address +: 32];
      else                        m_readdata <= 32'd0;
    end else begin
      m_readdata <= 32'd0;
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [41:0] obs();
    return {blk_ready, hash_valid, m_chipselect, m_write, m_read, m_address, m_writedata};
  endfunction

  // Expected {cs, wr, rd, addr, wdata} in cycle r after the accept cycle.
  function automatic logic [39:0] exp_bus(input int r, input logic [511:0] b);
    logic wr, rd;
    logic [4:0] a;
    logic [31:0] d;
    wr = 1'b0; rd = 1'b0; a = 5'd0; d = 32'd0;
    if (r >= 1 && r <= 16) begin
      wr = 1'b1; a = 5'(r - 1); d = b[32*(r-1) +: 32];
    end else if (r == 17) begin
      wr = 1'b1; a = 5'd16; d = 32'hFFFFFFFF;
    end else if (r >= 18 + W && r <= 25 + W) begin
      rd = 1'b1; a = 5'(r - 18 - W);
    end else if (r == 26 + W) begin
      wr = 1'b1; a = 5'd16; d = 32'h0F0F0F0F;
    end
    return {wr | rd, wr, rd, a, d};
  endfunction

  function automatic logic [511:0] mk_blk(input logic [31:0] base, input logic [31:0] step);
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = base + 32'(i) * step;
    return b;
  endfunction

  function automatic logic [255:0] mk_hash(input logic [31:0] base);
    logic [255:0] h;
    for (int k = 0; k < 8; k++) h[32*k +: 32] = base + 32'(k);
    return h;
  endfunction

  task automatic run_block(input logic [511:0] blk, input logic [255:0] hsh, input int hold,
                           input int abort_at, input bit keep, output int waits);
    rsp_hash  = hsh;
    blk_data  = blk;
    blk_valid = 1'b1;
    waits     = 0;
    while (!blk_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!blk_ready) begin
      check("accept_timeout", 256'(blk_ready), 256'd1);
      blk_valid = 1'b0;
      return;
    end
    for (int r = 1; r <= LAST; r++) begin
      @(negedge clk);
      if (r == 1) begin
        blk_data = ~blk;
        if (!keep) blk_valid = 1'b0;
      end
      check($sformatf("cyc%0d", r), 256'(obs()), 256'({1'b0, (r >= LAST), exp_bus(r, blk)}));
      if (r == abort_at) begin
        reset = 1'b1;
        #1;
        check("rst_async_out", 256'(obs()), 256'd0);
        check("rst_async_hash", hash_data, 256'd0);
        blk_valid = 1'b0;
        return;
      end
    end
    check("hash", hash_data, hsh);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check($sformatf("hold%0d_out", h), 256'(obs()), 256'({2'b01, 40'd0}));
      check($sformatf("hold%0d_hash", h), hash_data, hsh);
    end
    hash_ready = 1'b1;
    @(negedge clk);
    hash_ready = 1'b0;
    check("post_handshake", 256'({blk_ready, hash_valid}), 256'(2'b10));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int w;
    logic [511:0] abc_blk;
    logic [255:0] abc_h;
    abc_blk = '0;
    abc_blk[31:0]    = 32'h61626380;
    abc_blk[511:480] = 32'h00000018;
    abc_h = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
             32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};

    repeat (2) @(negedge clk);
    check("rst_out", 256'(obs()), 256'd0);
    check("rst_hash", hash_data, 256'd0);
    reset = 1'b0;
    @(negedge clk);
`ifdef ACC_HOST_PROBE_EN
    check("probe_read", 256'({blk_ready, m_read, m_address}), 256'({1'b0, 1'b1, 5'd17}));
`else
    check("rdy_first_clk", 256'(blk_ready), 256'd1);
`endif

    // Incrementing block, hash words A0+k.
    run_block(mk_blk(32'h00000100, 32'd1), mk_hash(32'h000000A0), 0, 0, 1'b0, w);
`ifdef ACC_HOST_PROBE_EN
    check("probe_err_set", 256'(probe_err), 256'd1);
`endif

    // Padded "abc" with digest returned by the accelerator, consumer stalls 20 cycles.
    run_block(abc_blk, abc_h, 20, 0, 1'b0, w);

    // Reset mid-LOAD, then a fresh block completes.
    run_block(mk_blk(32'h00000100, 32'd1), mk_hash(32'h000000A0), 0, 8, 1'b0, w);
    repeat (2) @(negedge clk);
    id_val = 32'h11111111;
    reset  = 1'b0;
    run_block(mk_blk(32'hDEAD0000, 32'h11), mk_hash(32'h000000B0), 2, 0, 1'b0, w);
`ifdef ACC_HOST_PROBE_EN
    check("probe_err_clear", 256'(probe_err), 256'd0);
`endif

    // Back-to-back with blk_valid held high.
    run_block(mk_blk(32'h5A5A0000, 32'h0101), mk_hash(32'h12340000), 0, 0, 1'b1, w);
    run_block(mk_blk(32'hC0DE0003, 32'h7), mk_hash(32'h0000C0C0), 1, 0, 1'b0, w);
    check("b2b_accept_wait", 256'(w), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_host.md
ACC_HOST -- requirements
Module: acc_host

Interface
- REQ-001 Parameter EXE_WAIT SHALL be EXE_WAIT, default 80: cycles between the start-command write and the first hash read (legal range 1..255).
- REQ-002 Port clk SHALL be: clk, input, 1 bit, the single clock; all logic on rising edge.
- REQ-003 Port reset SHALL be: reset, input, 1 bit, asynchronous active-high.
- REQ-004 Port blk_valid SHALL be: blk_valid, input, 1 bit, a 512-bit message block is offered.
- REQ-005 Port blk_ready SHALL be: blk_ready, output, 1 bit, block accepted when both blk_valid and blk_ready are high.
- REQ-006 Port blk_data SHALL be: blk_data, input, 512 bits, message block; word i is bits [32i+31:32i].
- REQ-007 Port hash_valid SHALL be: hash_valid, output, 1 bit, hash result available.
- REQ-008 Port hash_ready SHALL be: hash_ready, input, 1 bit, consumer takes the hash.
- REQ-009 Port hash_data SHALL be: hash_data, output, 256 bits, result; word k is bits [32k+31:32k].
- REQ-010 Avalon-MM host ports SHALL be: m_chipselect, m_write, m_read (output, 1 bit each); m_address (output, 5 bits); m_writedata (output, 32 bits); m_readdata (input, 32 bits, fixed read latency 1, no waitrequest).
- REQ-011 Port probe_err SHALL be: probe_err, output, 1 bit, sticky accelerator-ID mismatch (exists only with ACC_HOST_PROBE_EN).

Function
- REQ-012 The FSM SHALL have states IDLE, LOAD, START, WAIT, READ, ACK and OUT, plus PROBE under ACC_HOST_PROBE_EN.
- REQ-013 blk_ready SHALL be high only in IDLE; on accept (cycle C0), blk_data SHALL be latched internally and the FSM SHALL enter LOAD.
- REQ-014 LOAD SHALL issue one write per cycle in C1..C16, to address i=0..15, with word i of the latched block.
- REQ-015 START SHALL issue one write in C17 to address 16 with data 32'hFFFFFFFF.
- REQ-016 WAIT SHALL idle the bus for exactly EXE_WAIT cycles.
- REQ-017 READ SHALL issue reads to addresses 0..7 on 8 consecutive cycles, and capture m_readdata one cycle after each read into hash word k=address.
- REQ-018 ACK SHALL issue one write to address 16 with data 32'h0F0F0F0F in the cycle in which hash word 7 is captured.
- REQ-019 hash_valid SHALL rise in the cycle after ACK, i.e. cycle C27+EXE_WAIT (C107 at default).
- REQ-020 hash_data SHALL remain stable while hash_valid is high; on hash_valid&&hash_ready the FSM SHALL return to IDLE, and blk_ready SHALL be high the next cycle.
- REQ-021 m_chipselect SHALL equal m_write|m_read; m_write and m_read SHALL never be high together; m_address and m_writedata SHALL be 0 when idle.
- REQ-022 The bus SHALL carry at most one transaction per cycle and SHALL issue no transaction in IDLE, WAIT or OUT.
- REQ-023 blk_valid changes outside IDLE SHALL be ignored.

Reset
- REQ-024 Asserting reset in any state, including mid-LOAD or mid-READ, SHALL immediately force state IDLE, all bus outputs 0, hash_valid 0, hash_data 0, probe_err 0 and blk_ready 0.
- REQ-025 blk_ready SHALL rise on the first clock after reset deassertion, or after PROBE completes when probing is enabled.

Configuration
- REQ-026 With macro ACC_HOST_PROBE_EN defined, the first exit from reset SHALL pass through PROBE: a read of address 17, capture one cycle later, and probe_err set sticky if the value differs from 32'h11111111; operation SHALL then proceed to IDLE regardless.
- REQ-027 Without ACC_HOST_PROBE_EN, the PROBE state and the probe_err port SHALL be absent, and the FSM SHALL reset directly into IDLE.

Structure
- REQ-028 Shared package acc_pkg SHALL hold the state enum, ADDR_CTRL=16, ADDR_ID=17, CMD_START=32'hFFFFFFFF, CMD_ACK=32'h0F0F0F0F, CMD_RST=32'hFF0000FF and ID_VALUE=32'h11111111.
- REQ-029 Sub-module acc_host_timer SHALL implement the loadable EXE_WAIT down-counter with a done pulse; word counters SHALL stay in acc_host.

Verification
- REQ-030 Block with word i=32'h0000_0100+i, responder model returning hash words 32'hA0+k -> writes at addresses 0..15 in C1..C16, CMD_START at address 16 in C17, reads 0..7, hash_data word k=32'hA0+k, hash_valid at C107.
- REQ-031 Real accelerator, block "abc" padded -> hash_data equals SHA-256("abc")=ba7816bf...f20015ad in accelerator word order, followed by CMD_ACK at address 16.
- REQ-032 hash_ready held low for 20 cycles -> hash_valid and hash_data stable, no bus activity, blk_ready low throughout.
- REQ-033 reset asserted at C8 -> all outputs 0 asynchronously; a new block after release completes normally.
- REQ-034 With ACC_HOST_PROBE_EN and the model returning 32'h22222222 at address 17 -> probe_err=1, and a subsequent block still completes; with 32'h11111111 -> probe_err=0.
- REQ-035 Two back-to-back blocks with blk_valid held high -> second accept one cycle after the first hash handshake, and no overlapping bus transactions.
